// File: rtl/sys_mem_arb_pkg.sv
// Shared constants and types for the system-memory arbiter and its read-ID FIFO.
package sys_mem_arb_pkg;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    // Widest agent ID needed (up to 16 agents).
    localparam int ID_MAX_W = 4;

    typedef logic [ID_MAX_W-1:0] rd_id_t;

    function automatic int agent_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sys_mem_arb_id_fifo.sv
// Read-ID FIFO: remembers which agent issued each outstanding read.
module sys_mem_arb_id_fifo #(
    parameter int DEPTH = 8,
    parameter int ID_W  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [ID_W-1:0]        i_push_id,
    input  logic                   i_pop,
    output logic [ID_W-1:0]        o_head_id,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_id;
    end

    // Push and pop in the same cycle at full is fine: the head slot is read before it is rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_id = r_mem[r_rd_ptr];
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count   = r_count;

endmodule

// File: rtl/sys_mem_arb.sv
// N-agent system-memory arbiter (round-robin or fixed priority) with read-data return routing.
// Optional per-agent accept counters when SYS_MEM_ARB_PERF_CNTR_EN is defined.
module sys_mem_arb
    import sys_mem_arb_pkg::*;
#(
    parameter int NUM_AGENTS         = 2,
    parameter int SYS_MEM_DATA_W     = 32,
    parameter int SYS_MEM_ADDR_W     = 27,
    parameter int MAX_OUTSTANDING_RD = 8,
    parameter int ARB_MODE           = 0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    output logic [NUM_AGENTS-1:0]                      agent_mem_wait,
    input  logic [NUM_AGENTS-1:0]                      agent_mem_wren,
    input  logic [NUM_AGENTS-1:0]                      agent_mem_rden,
    input  logic [NUM_AGENTS-1:0][SYS_MEM_ADDR_W-1:0]  agent_mem_addr,
    input  logic [NUM_AGENTS-1:0][SYS_MEM_DATA_W-1:0]  agent_mem_wdata,
    output logic [NUM_AGENTS-1:0]                      agent_mem_rd_valid,
    output logic [NUM_AGENTS-1:0][SYS_MEM_DATA_W-1:0]  agent_mem_rdata,
    input  logic                                       sys_mem_wait,
    output logic                                       sys_mem_wren,
    output logic                                       sys_mem_rden,
    output logic [SYS_MEM_ADDR_W-1:0]                  sys_mem_addr,
    output logic [SYS_MEM_DATA_W-1:0]                  sys_mem_wdata,
    input  logic                                       sys_mem_rd_valid,
    input  logic [SYS_MEM_DATA_W-1:0]                  sys_mem_rdata,
    output logic                                       rd_orphan_err
`ifdef SYS_MEM_ARB_PERF_CNTR_EN
    ,
    output logic [NUM_AGENTS-1:0][31:0]                agent_acc_cnt
`endif
);
    localparam int ID_W  = agent_id_w(NUM_AGENTS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING_RD) + 1;

    logic              r_lock;
    logic [ID_W-1:0]   r_lock_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_orphan_err;

    logic [NUM_AGENTS-1:0] w_elig;
    logic                  w_gnt_vld;
    logic [ID_W-1:0]       w_gnt;
    logic                  w_gnt_wren;
    logic                  w_gnt_rden;
    logic                  w_accept;
    logic                  w_rd_acc;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [ID_W-1:0]       w_fifo_head;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [ID_W-1:0]       w_ret_id;

    // A same-cycle return frees a slot, so a full FIFO does not block reads that cycle.
    always_comb begin
        w_elig    = agent_mem_wren |
                    (agent_mem_rden & {NUM_AGENTS{!w_fifo_full | sys_mem_rd_valid}});
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        if (r_lock) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_lock_id;
        end else begin
            for (int j = NUM_AGENTS-1; j >= 0; j--) begin
                if (w_elig[j]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = ID_W'(j);
                end
            end
            if (ARB_MODE == ARB_MODE_RR) begin
                for (int j = NUM_AGENTS-1; j >= 0; j--) begin
                    if (w_elig[j] && (j >= int'(r_rr_ptr))) w_gnt = ID_W'(j);
                end
            end
        end
    end

    assign w_gnt_wren    = w_gnt_vld & agent_mem_wren[w_gnt];
    assign w_gnt_rden    = w_gnt_vld & agent_mem_rden[w_gnt] & !agent_mem_wren[w_gnt];
    assign w_accept      = (w_gnt_wren | w_gnt_rden) & !sys_mem_wait;
    assign sys_mem_wren  = w_gnt_wren;
    assign sys_mem_rden  = w_gnt_rden;
    assign sys_mem_addr  = w_gnt_vld ? agent_mem_addr[w_gnt]  : '0;
    assign sys_mem_wdata = w_gnt_vld ? agent_mem_wdata[w_gnt] : '0;

    always_comb begin
        agent_mem_wait = '1;
        if (w_gnt_vld) agent_mem_wait[w_gnt] = sys_mem_wait;
    end

    // Return into an empty FIFO during an accepted read goes straight to the reader.
    assign w_fifo_empty = (w_fifo_count == '0);
    assign w_rd_acc     = w_accept & w_gnt_rden;
    assign w_bypass     = w_rd_acc & sys_mem_rd_valid & w_fifo_empty;
    assign w_push       = w_rd_acc & !w_bypass;
    assign w_pop        = sys_mem_rd_valid & !w_fifo_empty;
    assign w_ret_id     = w_fifo_empty ? w_gnt : w_fifo_head;

    always_comb begin
        agent_mem_rd_valid = '0;
        if (w_pop | w_bypass) agent_mem_rd_valid[w_ret_id] = 1'b1;
    end

    assign agent_mem_rdata = {NUM_AGENTS{sys_mem_rdata}};
    assign rd_orphan_err   = r_orphan_err;

    sys_mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING_RD),
        .ID_W  (ID_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_push_id (w_gnt),
        .i_pop     (w_pop),
        .o_head_id (w_fifo_head),
        .o_full    (w_fifo_full),
        .o_count   (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock       <= 1'b0;
            r_lock_id    <= '0;
            r_rr_ptr     <= '0;
            r_orphan_err <= 1'b0;
        end else begin
            if ((w_gnt_wren | w_gnt_rden) & sys_mem_wait) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_gnt;
            end else if (w_accept) begin
                r_lock    <= 1'b0;
            end
            if ((ARB_MODE == ARB_MODE_RR) && w_accept) begin
                r_rr_ptr <= (w_gnt == ID_W'(NUM_AGENTS-1)) ? '0 : w_gnt + ID_W'(1);
            end
            if (sys_mem_rd_valid & w_fifo_empty & !w_rd_acc) r_orphan_err <= 1'b1;
        end
    end

`ifdef SYS_MEM_ARB_PERF_CNTR_EN
    logic [NUM_AGENTS-1:0][31:0] r_acc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_AGENTS; i++) begin
                if (w_accept && (w_gnt == ID_W'(i)) && (r_acc_cnt[i] != 32'hFFFF_FFFF)) begin
                    r_acc_cnt[i] <= r_acc_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign agent_acc_cnt = r_acc_cnt;
`endif

endmodule
